prng_arbiter: RTL and testbench
===============================

Name: prng_arbiter

Overview:
- Shares one PRNG output stream (valid/next/randomNumber handshake) between NUM_REQ consumers.
- Each consumer has its own valid/ready stream port.
- A round-robin scheduler grants the stream to one consumer at a time, for exactly one number per grant.
- Sits between the PRNG instance and the test/datapath consumers that would otherwise each need their own PRNG.

Parameters:
- NUM_REQ, 4, number of consumer ports (2..16).
- DATA_W, 4, random-number width; matches PRNG OUTPUT_SIZE.
- ID_W, $clog2(NUM_REQ), width of the grant index.
- CNT_W, 16, width of per-consumer statistics counters (optional feature only).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- prng_valid  in  1  PRNG has a number available.
- prng_data  in  DATA_W  PRNG random number.
- prng_next  out  1  advance the PRNG; a transfer occurs when prng_valid && prng_next.
- req_ready  in  NUM_REQ  per-consumer ready (request for one number).
- req_valid  out  NUM_REQ  per-consumer valid; at most one bit high.
- req_data  out  DATA_W  number broadcast to all consumers; qualified by req_valid.
- grant_id  out  ID_W  index of the current grant holder.
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset (async assert, sync release):
  - state=ARB, rr_ptr=0, grant_id=0, busy=0, prng_next=0, req_valid=0, req_data=0.
- FSM has two states, ARB and GRANT.
- ARB:
  - If req_ready==0: stay in ARB.
  - Otherwise: winner = first set bit of req_ready searching upward from rr_ptr, wrapping at NUM_REQ-1 to 0.
  - Register grant_id=winner and go to GRANT next cycle.
  - prng_next=0 and req_valid=0 throughout ARB.
- GRANT (combinational pass-through, zero added latency):
  - prng_next = req_ready[grant_id].
  - req_valid[grant_id] = prng_valid; all other bits 0.
  - req_data = prng_data while in GRANT; otherwise holds its last value (0 after reset).
  - Handshake = prng_valid && req_ready[grant_id]. On handshake: rr_ptr = (grant_id+1) mod NUM_REQ, state goes to ARB.
  - If req_ready[grant_id] drops before handshake: grant abandoned, state goes to ARB, rr_ptr unchanged (the same consumer keeps priority).
  - If prng_valid stays low: remain in GRANT indefinitely. No timeout.
- Throughput:
  - One number per 2 cycles maximum (ARB bubble plus GRANT transfer cycle).
  - The PRNG is never advanced without a consumer accepting the value, so no number is lost or duplicated.
- Fairness: with all ready bits held high, grants rotate 0,1,..,NUM_REQ-1,0. Any continuously requesting consumer waits at most NUM_REQ grants.
- Reset mid-GRANT: immediate return to ARB with all outputs at reset values. An in-flight value is discarded (not consumed, because prng_next drops).
- rr_ptr wrap: grant_id=NUM_REQ-1 handshake sets rr_ptr=0. Non-power-of-two NUM_REQ must wrap correctly (no out-of-range index).

Optional Feature:
- Macro: PRNG_ARB_STATS_EN.
- Defined:
  - Adds output grant_count, NUM_REQ x CNT_W, one counter per consumer.
  - A counter increments by 1 on each handshake for that consumer and saturates at all-ones (no wrap).
  - Adds input stats_clear (1 bit): synchronous zero of all counters; clear wins over a simultaneous increment.
  - Counters reset to 0.
- Undefined: no counters, ports absent, behaviour otherwise identical.

Decomposition:
- Shared package prng_arb_pkg:
  - state enum arb_state_e {ARB, GRANT}.
  - Function rr_pick(req, ptr) returning the winner index.
  - Default-parameter localparams.
- One sub-module, rr_priority_pick: purely combinational rotate/priority-encode of req_ready from rr_ptr.
  - Outputs: any, idx.
  - Reusable by other round-robin blocks in the test harness.

Test Plan:
- Reset with NUM_REQ=4, hold prng_valid=1 and req_ready=4'b0000 for 10 cycles -> prng_next=0, req_valid=0, busy=0 throughout.
- req_ready=4'b1111 held, prng_valid=1, prng_data incrementing 1,2,3... -> consumers 0,1,2,3,0 receive 1,2,3,4,5. One handshake every 2 cycles; no repeats or gaps.
- req_ready=4'b0100 only, prng_valid toggled 0 for 3 cycles -> grant_id=2, busy stays high, prng_next=1 and req_valid=4'b0100 only when prng_valid=1; single handshake, then back to ARB.
- Consumer 1 granted, drops ready before prng_valid rises, consumers 1 and 3 then request -> grant abandoned, next grant again to 1 (rr_ptr unchanged), then 3.
- Assert resetn=0 mid-GRANT with prng_valid=1 -> outputs 0 asynchronously. After release, the first grant goes to the lowest-index requester (rr_ptr=0).
- PRNG_ARB_STATS_EN, CNT_W=4, consumer 0 alone for 20 handshakes -> grant_count[0]=15 (saturated), others 0. stats_clear pulsed on the same cycle as a handshake -> counter becomes 0.

Source files
------------

// File: rtl/prng_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prng_arb_pkg
// Description : Shared types, defaults and round-robin pick helper for
//               prng_arbiter (optional stats: PRNG_ARB_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
package prng_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 4;
`ifdef PRNG_ARB_STATS_EN
    localparam int DEF_CNT_W   = 16;
`endif
    localparam int MAX_REQ     = 16;
    localparam int MAX_ID_W    = 4;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // First set bit of req at or above ptr, wrapping at n-1; 0 when none set.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                            input int unsigned        ptr,
                                            input int unsigned        n);
        int unsigned k;
        int unsigned win;
        logic        found;
        win   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            k = ptr + i;
            if (k >= n) k = k - n;
            if (i < n && k < n && !found && req[k[MAX_ID_W-1:0]]) begin
                win   = k;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prng_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : prng_arbiter_if
// Description : PRNG-side and consumer-side stream signals of prng_arbiter
//               (stats signals present with PRNG_ARB_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
interface prng_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
`ifdef PRNG_ARB_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
);
    logic                prng_valid;
    logic [DATA_W-1:0]   prng_data;
    logic                prng_next;
    logic [NUM_REQ-1:0]  req_ready;
    logic [NUM_REQ-1:0]  req_valid;
    logic [DATA_W-1:0]   req_data;
    logic [ID_W-1:0]     grant_id;
    logic                busy;
`ifdef PRNG_ARB_STATS_EN
    logic                           stats_clear;
    logic [NUM_REQ-1:0][CNT_W-1:0]  grant_count;
`endif

    modport master (
        input  prng_valid, prng_data, req_ready,
`ifdef PRNG_ARB_STATS_EN
        input  stats_clear,
        output grant_count,
`endif
        output prng_next, req_valid, req_data, grant_id, busy
    );

    modport slave (
        output prng_valid, prng_data, req_ready,
`ifdef PRNG_ARB_STATS_EN
        output stats_clear,
        input  grant_count,
`endif
        input  prng_next, req_valid, req_data, grant_id, busy
    );

endinterface
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin priority encoder: first request at
//               or above i_ptr, wrapping at NUM_REQ-1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import prng_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [ID_W-1:0]    i_ptr,
    output logic                    o_any,
    output logic [ID_W-1:0]         o_idx
);

    assign o_any = |i_req;
    assign o_idx = ID_W'(rr_pick(MAX_REQ'(i_req), 32'(i_ptr), NUM_REQ));

endmodule
`default_nettype wire

// File: rtl/prng_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prng_arbiter
// Description : Round-robin sharing of one PRNG stream among NUM_REQ
//               consumers, one number per grant. Define PRNG_ARB_STATS_EN for
//               saturating per-consumer grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module prng_arbiter
    import prng_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
`ifdef PRNG_ARB_STATS_EN
    ,
    parameter int CNT_W   = DEF_CNT_W
`endif
) (
    input  wire logic      clk,
    input  wire logic      resetn,
    prng_arbiter_if.master bus
);

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [DATA_W-1:0]   r_req_data;
    logic                w_pick_any;
    logic [ID_W-1:0]     w_pick_idx;
    logic                w_ready_gid;
    logic                w_handshake;
    logic                w_prng_next;
    logic [NUM_REQ-1:0]  w_req_valid;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req   (bus.req_ready),
        .i_ptr   (r_rr_ptr),
        .o_any   (w_pick_any),
        .o_idx   (w_pick_idx)
    );

    assign w_ready_gid = bus.req_ready[r_grant_id];
    assign w_handshake = (r_state == GRANT) && bus.prng_valid && w_ready_gid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ARB;
        end else begin
            r_state <= w_next_state;
        end
    end

    // GRANT is a pure pass-through; it ends on either a transfer or abandonment.
    always_comb begin
        w_next_state = r_state;
        w_prng_next  = 1'b0;
        w_req_valid  = '0;
        case (r_state)
            ARB: begin
                if (w_pick_any) w_next_state = GRANT;
            end
            GRANT: begin
                w_prng_next             = w_ready_gid;
                w_req_valid[r_grant_id] = bus.prng_valid;
                if (!w_ready_gid || bus.prng_valid) w_next_state = ARB;
            end
            default: w_next_state = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_req_data <= '0;
        end else begin
            if (r_state == ARB && w_pick_any) r_grant_id <= w_pick_idx;
            if (r_state == GRANT)             r_req_data <= bus.prng_data;
            // Abandoned grants leave the pointer alone so the same consumer keeps priority.
            if (w_handshake) begin
                r_rr_ptr <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
            end
        end
    end

    assign bus.prng_next = w_prng_next;
    assign bus.req_valid = w_req_valid;
    assign bus.req_data  = (r_state == GRANT) ? bus.prng_data : r_req_data;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = (r_state == GRANT);

`ifdef PRNG_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] r_grant_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_grant_count <= '0;
        end else if (bus.stats_clear) begin
            r_grant_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_handshake && r_grant_id == ID_W'(i) &&
                    r_grant_count[i] != {CNT_W{1'b1}}) begin
                    r_grant_count[i] <= r_grant_count[i] + 1'b1;
                end
            end
        end
    end

    assign bus.grant_count = r_grant_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prng_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prng_arbiter
// Description : Directed self-checking bench for prng_arbiter (NUM_REQ=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prng_arbiter;

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;

`ifdef PRNG_ARB_STATS_EN
    prng_arbiter_if #(.NUM_REQ(4), .DATA_W(4), .ID_W(2), .CNT_W(4)) bus ();
    prng_arbiter #(.NUM_REQ(4), .DATA_W(4), .ID_W(2), .CNT_W(4)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );
`else
    prng_arbiter_if #(.NUM_REQ(4), .DATA_W(4), .ID_W(2)) bus ();
    prng_arbiter #(.NUM_REQ(4), .DATA_W(4), .ID_W(2)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic drive_cycle(input logic [3:0] rdy, input logic vld, input logic [3:0] dat);
        @(negedge clk);
        bus.req_ready  = rdy;
        bus.prng_valid = vld;
        bus.prng_data  = dat;
        #1;
    endtask

    task automatic test_reset();
        bus.prng_valid = 1'b1;
        bus.req_ready  = 4'b0000;
        #1;
        n_tests++;
        if (bus.prng_next !== 1'b0 || bus.req_valid !== 4'b0000 || bus.busy !== 1'b0 ||
            bus.grant_id !== 2'd0 || bus.req_data !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got next=%b valid=%b busy=%b id=%0d data=%0d, want all 0",
                     bus.prng_next, bus.req_valid, bus.busy, bus.grant_id, bus.req_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(4'b0000, 1'b1, 4'd5);
            n_tests++;
            if (bus.prng_next !== 1'b0 || bus.req_valid !== 4'b0000 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got next=%b valid=%b busy=%b, want 0 0000 0",
                         c, bus.prng_next, bus.req_valid, bus.busy);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] val;
        logic [1:0] exp_id;
        int         hs;
        int         last;
        val    = 4'd1;
        exp_id = 2'd0;
        hs     = 0;
        last   = 0;
        for (int cyc = 0; cyc < 30 && hs < 5; cyc++) begin
            drive_cycle(4'b1111, 1'b1, val);
            if (bus.prng_next) begin
                n_tests++;
                if (bus.grant_id !== exp_id || bus.req_valid !== (4'b0001 << exp_id) ||
                    bus.req_data !== val) begin
                    n_fail++;
                    $display("FAIL rot_xfer%0d: got id=%0d valid=%b data=%0d, want id=%0d valid=%b data=%0d",
                             hs, bus.grant_id, bus.req_valid, bus.req_data,
                             exp_id, 4'b0001 << exp_id, val);
                end
                if (hs > 0) begin
                    n_tests++;
                    if (cyc - last != 2) begin
                        n_fail++;
                        $display("FAIL rot_gap%0d: got %0d cycles, want 2", hs, cyc - last);
                    end
                end
                last   = cyc;
                hs     = hs + 1;
                val    = val + 4'd1;
                exp_id = exp_id + 2'd1;
            end
        end
        n_tests++;
        if (hs != 5) begin
            n_fail++;
            $display("FAIL rot_count: got %0d handshakes, want 5", hs);
        end
        drive_cycle(4'b0000, 1'b0, 4'd0);
    endtask

    task automatic test_abandon();
        drive_cycle(4'b0010, 1'b0, 4'd0);
        drive_cycle(4'b0010, 1'b0, 4'd0);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1 || bus.req_valid !== 4'b0000 ||
            bus.prng_next !== 1'b1) begin
            n_fail++;
            $display("FAIL abandon_grant: got busy=%b id=%0d valid=%b next=%b, want 1 1 0000 1",
                     bus.busy, bus.grant_id, bus.req_valid, bus.prng_next);
        end
        drive_cycle(4'b0000, 1'b0, 4'd0);
        n_tests++;
        if (bus.prng_next !== 1'b0) begin
            n_fail++;
            $display("FAIL abandon_drop: got next=%b, want 0", bus.prng_next);
        end
        drive_cycle(4'b1010, 1'b1, 4'd7);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.prng_next !== 1'b0) begin
            n_fail++;
            $display("FAIL abandon_arb: got busy=%b next=%b, want 0 0", bus.busy, bus.prng_next);
        end
        drive_cycle(4'b1010, 1'b1, 4'd7);
        n_tests++;
        if (bus.grant_id !== 2'd1 || bus.req_valid !== 4'b0010 || bus.req_data !== 4'd7 ||
            bus.prng_next !== 1'b1) begin
            n_fail++;
            $display("FAIL abandon_regrant: got id=%0d valid=%b data=%0d next=%b, want 1 0010 7 1",
                     bus.grant_id, bus.req_valid, bus.req_data, bus.prng_next);
        end
        drive_cycle(4'b1010, 1'b1, 4'd8);
        drive_cycle(4'b1010, 1'b1, 4'd8);
        n_tests++;
        if (bus.grant_id !== 2'd3 || bus.req_valid !== 4'b1000 || bus.req_data !== 4'd8) begin
            n_fail++;
            $display("FAIL abandon_next: got id=%0d valid=%b data=%0d, want 3 1000 8",
                     bus.grant_id, bus.req_valid, bus.req_data);
        end
        drive_cycle(4'b0000, 1'b0, 4'd0);
    endtask

    task automatic test_stall();
        drive_cycle(4'b0100, 1'b0, 4'd0);
        for (int c = 0; c < 3; c++) begin
            drive_cycle(4'b0100, 1'b0, 4'd0);
            n_tests++;
            if (bus.busy !== 1'b1 || bus.grant_id !== 2'd2 || bus.req_valid !== 4'b0000 ||
                bus.prng_next !== 1'b1) begin
                n_fail++;
                $display("FAIL stall%0d: got busy=%b id=%0d valid=%b next=%b, want 1 2 0000 1",
                         c, bus.busy, bus.grant_id, bus.req_valid, bus.prng_next);
            end
        end
        drive_cycle(4'b0100, 1'b1, 4'd9);
        n_tests++;
        if (bus.req_valid !== 4'b0100 || bus.req_data !== 4'd9 || bus.prng_next !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_xfer: got valid=%b data=%0d next=%b, want 0100 9 1",
                     bus.req_valid, bus.req_data, bus.prng_next);
        end
        drive_cycle(4'b0000, 1'b1, 4'd3);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.req_valid !== 4'b0000 || bus.req_data !== 4'd9 ||
            bus.prng_next !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_after: got busy=%b valid=%b data=%0d next=%b, want 0 0000 9 0",
                     bus.busy, bus.req_valid, bus.req_data, bus.prng_next);
        end
    endtask

    task automatic test_reset_mid_grant();
        drive_cycle(4'b1001, 1'b0, 4'd0);
        drive_cycle(4'b1001, 1'b1, 4'd5);
        n_tests++;
        if (bus.grant_id !== 2'd3 || bus.req_valid !== 4'b1000 || bus.prng_next !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got id=%0d valid=%b next=%b, want 3 1000 1",
                     bus.grant_id, bus.req_valid, bus.prng_next);
        end
        resetn = 1'b0;
        #1;
        n_tests++;
        if (bus.prng_next !== 1'b0 || bus.req_valid !== 4'b0000 || bus.busy !== 1'b0 ||
            bus.grant_id !== 2'd0 || bus.req_data !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_async: got next=%b valid=%b busy=%b id=%0d data=%0d, want all 0",
                     bus.prng_next, bus.req_valid, bus.busy, bus.grant_id, bus.req_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        drive_cycle(4'b1001, 1'b1, 4'd6);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0 || bus.req_valid !== 4'b0001 ||
            bus.req_data !== 4'd6) begin
            n_fail++;
            $display("FAIL rst_first_grant: got busy=%b id=%0d valid=%b data=%0d, want 1 0 0001 6",
                     bus.busy, bus.grant_id, bus.req_valid, bus.req_data);
        end
        drive_cycle(4'b0000, 1'b0, 4'd0);
    endtask

`ifdef PRNG_ARB_STATS_EN
    task automatic test_stats();
        int hs;
        hs = 0;
        drive_cycle(4'b0000, 1'b0, 4'd0);
        bus.stats_clear = 1'b1;
        drive_cycle(4'b0000, 1'b0, 4'd0);
        bus.stats_clear = 1'b0;
        for (int c = 0; c < 40; c++) begin
            drive_cycle(4'b0001, 1'b1, 4'(c));
            if (bus.prng_next && bus.prng_valid) hs++;
        end
        drive_cycle(4'b0000, 1'b0, 4'd0);
        n_tests++;
        if (hs != 20 || bus.grant_count[0] !== 4'd15 || bus.grant_count[1] !== 4'd0 ||
            bus.grant_count[2] !== 4'd0 || bus.grant_count[3] !== 4'd0) begin
            n_fail++;
            $display("FAIL stats_sat: got hs=%0d cnt=%h, want hs=20 cnt=000f", hs, bus.grant_count);
        end
        drive_cycle(4'b0001, 1'b1, 4'd1);
        drive_cycle(4'b0001, 1'b1, 4'd1);
        bus.stats_clear = 1'b1;
        n_tests++;
        if (bus.prng_next !== 1'b1) begin
            n_fail++;
            $display("FAIL stats_clear_hs: got next=%b, want 1", bus.prng_next);
        end
        drive_cycle(4'b0000, 1'b0, 4'd0);
        bus.stats_clear = 1'b0;
        n_tests++;
        if (bus.grant_count[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL stats_clear: got %0d, want 0", bus.grant_count[0]);
        end
    endtask
`endif

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        resetn         = 1'b0;
        bus.prng_valid = 1'b0;
        bus.prng_data  = 4'd0;
        bus.req_ready  = 4'b0000;
`ifdef PRNG_ARB_STATS_EN
        bus.stats_clear = 1'b0;
`endif
        repeat (2) @(posedge clk);
        test_reset();
        test_rotation();
        test_abandon();
        test_stall();
        test_reset_mid_grant();
`ifdef PRNG_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
